// File: rtl/ram_init_write_stage.sv
// Registered write-port stage in front of the multi-port RAMs: sweeps every entry
// through port 0 after reset or on request, then forwards gated functional writes.
module ram_init_write_stage #(
  parameter int DEPTH        = 128,
  parameter int INDEX        = 7,
  parameter int WIDTH        = 7,
  parameter int NUM_WR_PORTS = 4,
  parameter int RESET_VAL    = 0,
  parameter int SEQ_START    = 0
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   initReq_i,
  input  logic [NUM_WR_PORTS-1:0]                writePortGated_i,
  input  logic [NUM_WR_PORTS-1:0]                wrEn_i,
  input  logic [NUM_WR_PORTS-1:0][INDEX-1:0]     addrWr_i,
  input  logic [NUM_WR_PORTS-1:0][WIDTH-1:0]     dataWr_i,
  output logic [NUM_WR_PORTS-1:0]                wrEn_o,
  output logic [NUM_WR_PORTS-1:0][INDEX-1:0]     addrWr_o,
  output logic [NUM_WR_PORTS-1:0][WIDTH-1:0]     dataWr_o,
  output logic                                   ramReady_o,
  output logic                                   wrDropped_o
);

  typedef enum logic {INIT, READY} stateT;

  stateT                               state, stateNext;
  logic [INDEX-1:0]                    initCnt, initCntNext;
  logic [NUM_WR_PORTS-1:0]             wrEnNext;
  logic [NUM_WR_PORTS-1:0][INDEX-1:0]  addrNext;
  logic [NUM_WR_PORTS-1:0][WIDTH-1:0]  dataNext;
  logic                                readyNext;
  logic                                droppedNext;
  logic [NUM_WR_PORTS-1:0]             liveWr;
  logic                                lastEntry;
  logic [WIDTH-1:0]                    sweepData;

  assign liveWr    = wrEn_i & ~writePortGated_i;
  assign lastEntry = (initCnt == INDEX'(DEPTH - 1));
  // Sequential pattern wraps naturally by truncation to WIDTH bits.
  assign sweepData = (RESET_VAL == 1) ? (WIDTH'(SEQ_START) + WIDTH'(initCnt)) : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= INIT;
      initCnt     <= '0;
      wrEn_o      <= '0;
      addrWr_o    <= '0;
      dataWr_o    <= '0;
      ramReady_o  <= 1'b0;
      wrDropped_o <= 1'b0;
    end else begin
      state       <= stateNext;
      initCnt     <= initCntNext;
      wrEn_o      <= wrEnNext;
      addrWr_o    <= addrNext;
      dataWr_o    <= dataNext;
      ramReady_o  <= readyNext;
      wrDropped_o <= droppedNext;
    end
  end

  always_comb begin
    stateNext   = state;
    initCntNext = initCnt;
    case (state)
      INIT: begin
        if (lastEntry) begin
          stateNext   = READY;
          initCntNext = '0;
        end else begin
          initCntNext = initCnt + INDEX'(1);
        end
      end
      READY: begin
        if (initReq_i) begin
          stateNext   = INIT;
          initCntNext = '0;
        end
      end
    endcase
  end

  // Gated lanes drive zero address/data so the RAM inputs stay quiet.
  always_comb begin
    wrEnNext    = '0;
    addrNext    = '0;
    dataNext    = '0;
    readyNext   = (state == READY);
    droppedNext = wrDropped_o;
    case (state)
      INIT: begin
        wrEnNext[0] = 1'b1;
        addrNext[0] = initCnt;
        dataNext[0] = sweepData;
        if (|liveWr) droppedNext = 1'b1;
      end
      READY: begin
        wrEnNext = liveWr;
        for (int p = 0; p < NUM_WR_PORTS; p++) begin
          if (!writePortGated_i[p]) begin
            addrNext[p] = addrWr_i[p];
            dataNext[p] = dataWr_i[p];
          end
        end
        if (initReq_i) begin
          readyNext   = 1'b0;
          droppedNext = 1'b0;
        end
      end
    endcase
  end

endmodule
